// File: rtl/mem_pipe.sv
// mem_pipe: simple-dual-port RAM with byte enables, selectable read latency, RDW mode and clear sequencer
module mem_pipe #(
  parameter int    WIDTH          = 32,
  parameter int    DEPTH          = 256,
  parameter int    BYTE           = 8,
  parameter int    RD_LAT         = 1,
  parameter bit    RDW_MODE       = 1'b0,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string FILE           = "",
  localparam int   LANES          = WIDTH / BYTE,
  localparam int   AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LANES-1:0] byteena_i,
  input  logic [AW-1:0]    wraddress_i,
  input  logic             wren_i,
  input  logic [AW-1:0]    rdaddress_i,
  input  logic             rden_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             busy_o
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    clr_q, clr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en, rd_ok;
  logic [WIDTH-1:0] rd_word, rd_data, s1_data_q;
  logic             s1_vld_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == AW'(DEPTH - 1)) state_d = READY;
    end
  end
  assign busy_o = state_q == CLEAR;
  assign wr_en  = !reset_i && !busy_o && wren_i && (32'(wraddress_i) < DEPTH);
  assign rd_en  = !reset_i && !busy_o && rden_i;
  assign rd_ok  = 32'(rdaddress_i) < DEPTH;
  always_ff @(posedge clock_i) begin
    if (!reset_i && busy_o)
      mem_q[clr_q] <= '0;
    else if (wr_en)
      for (int i = 0; i < LANES; i++)
        if (byteena_i[i]) mem_q[wraddress_i][i*BYTE +: BYTE] <= data_i[i*BYTE +: BYTE];
  end
  always_comb begin
    rd_word = rd_ok ? mem_q[rdaddress_i] : '0;
    rd_data = rd_word;
    for (int i = 0; i < LANES; i++)
      if (RDW_MODE && wr_en && wraddress_i == rdaddress_i && byteena_i[i])
        rd_data[i*BYTE +: BYTE] = data_i[i*BYTE +: BYTE];
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= rd_en;
      if (rd_en) s1_data_q <= rd_data;
    end
  end
  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        vld_q <= s1_vld_q;
        if (s1_vld_q) data_q <= s1_data_q;
      end
    end
    assign q_o       = data_q;
    assign q_valid_o = vld_q;
  end else begin : g_lat1
    assign q_o       = s1_data_q;
    assign q_valid_o = s1_vld_q;
  end
endmodule
